// File: rtl/instruction_fetch.sv
// Instruction fetch unit: sequential PC generation, one-cycle-latency memory
// requests and a two-entry {pc, instruction} buffer feeding decode.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read_enable,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instruction,
  output logic [31:0] fetch_pc
);

  localparam logic [2:0]  DEPTH_L = 3'(DEPTH);
  localparam logic [31:0] STEP_L  = 32'(PC_STEP);

  logic [31:0] pc_q, pc_d;
  logic [31:0] tag_q, tag_d;
  logic        inflight_q, inflight_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] buf_pc_q    [DEPTH];
  logic [31:0] buf_instr_q [DEPTH];

  logic        flush;
  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  level;

  // Handshake: decode pops the head in any cycle where fetch_valid and
  // fetch_ready are both high; fetch_valid never depends on fetch_ready.
  assign flush       = rst | redirect_valid;
  assign fetch_valid = !flush && (count_q != 2'd0);
  assign pop         = fetch_valid && fetch_ready;
  assign push        = inflight_q && !flush;

  // Occupancy after this cycle counts the in-flight response, so a granted
  // request always finds a free slot when its data arrives.
  assign level = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = !flush && (level < DEPTH_L);

  assign imem_read_enable  = issue;
  assign imem_address      = pc_q;
  assign fetch_pc          = buf_pc_q[rd_ptr_q];
  assign fetch_instruction = buf_instr_q[rd_ptr_q];

  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (rst) begin
      pc_d     = RESET_PC;
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else if (redirect_valid) begin
      pc_d     = redirect_pc;
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (issue) begin
        pc_d  = pc_q + STEP_L;
        tag_d = pc_q;
      end
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      tag_q      <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer payload needs no reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]    <= tag_q;
      buf_instr_q[wr_ptr_q] <= imem_instruction;
    end
  end

endmodule
